// File: rtl/deserializer_pkg.sv
// Shared types and default widths for the 7-bit value stream deserializer.
package deserializer_pkg;

   localparam int unsigned DEF_VALUE_W = 7;
   localparam int unsigned DEF_WORD_W  = 32;
   localparam int unsigned DEF_CNT_W   = $clog2(DEF_WORD_W + DEF_VALUE_W);
   localparam int unsigned PAD_W       = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_t;

endpackage

// File: rtl/deserializer_if.sv
// Value-in / word-out handshake bundle; slave side is the deserializer.
interface deserializer_if
   import deserializer_pkg::*;
#(
   parameter int unsigned VALUE_W = DEF_VALUE_W,
   parameter int unsigned WORD_W  = DEF_WORD_W
);

   logic               valid_in;
   logic               first_value;
   logic               last_value;
   logic [VALUE_W-1:0] data_in;
   logic               ready_out;
   logic               word_valid;
   logic [WORD_W-1:0]  word_out;
   logic               first_word;
   logic               last_word;
   logic [PAD_W-1:0]   pad_bits;
   logic               packet_in_progress;
   logic               proto_err;

   modport master (
      output valid_in, first_value, last_value, data_in,
      input  ready_out, word_valid, word_out, first_word, last_word,
             pad_bits, packet_in_progress, proto_err
   );

   modport slave (
      input  valid_in, first_value, last_value, data_in,
      output ready_out, word_valid, word_out, first_word, last_word,
             pad_bits, packet_in_progress, proto_err
   );

endinterface

// File: rtl/deserializer_bit_packer.sv
// Left-justified bit accumulator: appends values, extracts full words,
// and produces zero-padded final words on last value or flush.
module deserializer_bit_packer
   import deserializer_pkg::*;
#(
   parameter int unsigned VALUE_W = DEF_VALUE_W,
   parameter int unsigned WORD_W  = DEF_WORD_W,
   parameter int unsigned CNT_W   = $clog2(WORD_W + VALUE_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_clr,
   input  logic               i_last,
   input  logic               i_flush,
   input  logic [VALUE_W-1:0] i_value,
   output logic               o_emit,
   output logic [WORD_W-1:0]  o_word,
   output logic [PAD_W-1:0]   o_pad,
   output logic               o_overflow
);

   localparam int unsigned ACC_W = WORD_W + VALUE_W - 1;

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [ACC_W-1:0] w_base_acc;
   logic [CNT_W-1:0] w_base_cnt;
   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_comb;
   logic [CNT_W-1:0] w_total;
   logic             w_full;

   // i_clr lets a restarting packet append onto an empty accumulator in the same cycle
   assign w_base_acc = i_clr ? '0 : r_acc;
   assign w_base_cnt = i_clr ? '0 : r_cnt;
   assign w_ext      = {i_value, {(ACC_W - VALUE_W){1'b0}}};
   assign w_comb     = w_base_acc | (w_ext >> w_base_cnt);
   assign w_total    = w_base_cnt + CNT_W'(VALUE_W);
   assign w_full     = (w_total >= CNT_W'(WORD_W));
   assign o_overflow = (w_total > CNT_W'(WORD_W));

   always_comb begin
      o_emit    = 1'b0;
      o_word    = w_comb[ACC_W-1 -: WORD_W];
      o_pad     = '0;
      w_acc_nxt = r_acc;
      w_cnt_nxt = r_cnt;
      if (i_flush) begin
         o_emit    = 1'b1;
         o_word    = r_acc[ACC_W-1 -: WORD_W];
         o_pad     = PAD_W'(CNT_W'(WORD_W) - r_cnt);
         w_acc_nxt = '0;
         w_cnt_nxt = '0;
      end else if (i_load) begin
         if (w_full) begin
            o_emit    = 1'b1;
            w_acc_nxt = {w_comb[ACC_W-WORD_W-1:0], {WORD_W{1'b0}}};
            w_cnt_nxt = w_total - CNT_W'(WORD_W);
         end else if (i_last) begin
            o_emit    = 1'b1;
            o_pad     = PAD_W'(CNT_W'(WORD_W) - w_total);
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
         end else begin
            w_acc_nxt = w_comb;
            w_cnt_nxt = w_total;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else begin
         r_acc <= w_acc_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/deserializer.sv
// Packet framing FSM around the bit packer: restores the word stream from
// framed 7-bit values, with first/last word markers and protocol error flag.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int unsigned VALUE_W = DEF_VALUE_W,
   parameter int unsigned WORD_W  = DEF_WORD_W
) (
   input  logic           clk,
   input  logic           rst,
   deserializer_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WORD_W + VALUE_W);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_ready;
   logic              w_load;
   logic              w_clr;
   logic              w_flush;
   logic              w_last_in;
   logic              w_perr_set;
   logic              w_emit;
   logic              w_emit_last;
   logic              w_is_first;
   logic              w_overflow;
   logic [WORD_W-1:0] w_word;
   logic [PAD_W-1:0]  w_pad;

   logic              r_first_pend;
   logic              r_word_valid;
   logic [WORD_W-1:0] r_word;
   logic              r_first_word;
   logic              r_last_word;
   logic [PAD_W-1:0]  r_pad;
   logic              r_proto_err;

   // Kept outside the FSM block so the packer overflow flag never loops back through it
   assign w_clr = bus.first_value && (r_state != FLUSH);

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b1;
      w_load      = 1'b0;
      w_flush     = 1'b0;
      w_last_in   = 1'b0;
      w_perr_set  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.valid_in) begin
               if (bus.first_value) begin
                  w_load      = 1'b1;
                  w_last_in   = bus.last_value;
                  w_state_nxt = bus.last_value ? (w_overflow ? FLUSH : IDLE) : ACTIVE;
               end else begin
                  w_perr_set  = 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (bus.valid_in) begin
               w_load      = 1'b1;
               w_last_in   = bus.last_value;
               w_perr_set  = bus.first_value;
               w_state_nxt = bus.last_value ? (w_overflow ? FLUSH : IDLE) : ACTIVE;
            end
         end
         FLUSH: begin
            w_ready     = 1'b0;
            w_flush     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   deserializer_bit_packer #(
      .VALUE_W (VALUE_W),
      .WORD_W  (WORD_W),
      .CNT_W   (CNT_W)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_clr      (w_clr),
      .i_last     (w_last_in),
      .i_flush    (w_flush),
      .i_value    (bus.data_in),
      .o_emit     (w_emit),
      .o_word     (w_word),
      .o_pad      (w_pad),
      .o_overflow (w_overflow)
   );

   assign w_emit_last = w_flush || (w_load && w_last_in && !w_overflow);
   assign w_is_first  = (w_load && bus.first_value) || r_first_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_first_pend <= 1'b0;
         r_word_valid <= 1'b0;
         r_word       <= '0;
         r_first_word <= 1'b0;
         r_last_word  <= 1'b0;
         r_pad        <= '0;
         r_proto_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_first_pend <= w_is_first && !w_emit;
         r_word_valid <= w_emit;
         if (w_emit) begin
            r_word <= w_word;
         end
         r_first_word <= w_emit && w_is_first;
         r_last_word  <= w_emit && w_emit_last;
         r_pad        <= w_emit ? w_pad : '0;
         r_proto_err  <= r_proto_err || w_perr_set;
      end
   end

   assign bus.ready_out          = w_ready;
   assign bus.word_valid         = r_word_valid;
   assign bus.word_out           = r_word;
   assign bus.first_word         = r_first_word;
   assign bus.last_word          = r_last_word;
   assign bus.pad_bits           = r_pad;
   assign bus.packet_in_progress = (r_state != IDLE);
   assign bus.proto_err          = r_proto_err;

endmodule

// File: tb/tb_deserializer.sv
// Directed table-driven bench for the deserializer, plus hand sequences for
// the 32-value stream and the asynchronous reset mid-packet.
module tb_deserializer;

   localparam int unsigned VW = 7;
   localparam int unsigned WW = 32;

   logic clk = 1'b0;
   logic rst;

   deserializer_if #(.VALUE_W(VW), .WORD_W(WW)) bus ();

   deserializer #(.VALUE_W(VW), .WORD_W(WW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        v;
      logic        f;
      logic        l;
      logic [6:0]  d;
      logic        wv;
      logic [31:0] wo;
      logic        fw;
      logic        lw;
      logic [4:0]  pad;
      logic        rdy;
      logic        pip;
      logic        perr;
   } vec_t;

   vec_t tbl[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic vec_t mk(string n, logic v, logic f, logic l, logic [6:0] d,
                               logic wv, logic [31:0] wo, logic fw, logic lw,
                               logic [4:0] pad, logic rdy, logic pip, logic perr);
      vec_t r;
      r.name = n; r.v = v; r.f = f; r.l = l; r.d = d;
      r.wv = wv; r.wo = wo; r.fw = fw; r.lw = lw; r.pad = pad;
      r.rdy = rdy; r.pip = pip; r.perr = perr;
      return r;
   endfunction

   task automatic apply(logic v, logic f, logic l, logic [6:0] d);
      @(negedge clk);
      bus.valid_in    = v;
      bus.first_value = f;
      bus.last_value  = l;
      bus.data_in     = d;
      @(posedge clk);
      #1;
   endtask

   // Layout: {word_valid, first_word, last_word, pad_bits, ready_out, pip, proto_err, word_out}
   task automatic check_out(string name, logic ewv, logic [31:0] ewo, logic efw, logic elw,
                            logic [4:0] epad, logic erdy, logic epip, logic eperr);
      logic [42:0] got;
      logic [42:0] exp;
      got = {bus.word_valid, bus.first_word, bus.last_word, bus.pad_bits, bus.ready_out,
             bus.packet_in_progress, bus.proto_err, (ewv ? bus.word_out : 32'h0)};
      exp = {ewv, efw, elw, epad, erdy, epip, eperr, (ewv ? ewo : 32'h0)};
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h required %h (wv,fw,lw,pad,rdy,pip,perr,word)", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      bus.valid_in    = 1'b0;
      bus.first_value = 1'b0;
      bus.last_value  = 1'b0;
      bus.data_in     = '0;

      //             name          v  f  l  d       wv wo            fw lw pad    rdy pip perr
      tbl.push_back(mk("t1_v0",    1, 1, 0, 7'h78, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t1_v1",    1, 0, 0, 7'h03, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t1_v2",    1, 0, 0, 7'h18, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t1_v3",    1, 0, 0, 7'h05, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t1_word",  1, 0, 0, 7'h50, 1, 32'hF00CC05A, 1, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t1_end",   1, 0, 1, 7'h7F, 1, 32'h1FC00000, 0, 1, 5'd22, 1, 0, 0));
      tbl.push_back(mk("gap",      0, 0, 0, 7'h00, 0, 32'h0,        0, 0, 5'd0,  1, 0, 0));
      tbl.push_back(mk("t2_single",1, 1, 1, 7'h7F, 1, 32'hFE000000, 1, 1, 5'd25, 1, 0, 0));
      tbl.push_back(mk("t3_v0",    1, 1, 0, 7'h7F, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t3_v1",    1, 0, 0, 7'h7F, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t3_v2",    1, 0, 0, 7'h7F, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t3_v3",    1, 0, 0, 7'h7F, 0, 32'h0,        0, 0, 5'd0,  1, 1, 0));
      tbl.push_back(mk("t3_full",  1, 0, 1, 7'h7F, 1, 32'hFFFFFFFF, 1, 0, 5'd0,  0, 1, 0));
      tbl.push_back(mk("t3_flush", 1, 1, 1, 7'h55, 1, 32'hE0000000, 0, 1, 5'd29, 1, 0, 0));
      tbl.push_back(mk("t3_idle",  0, 0, 0, 7'h00, 0, 32'h0,        0, 0, 5'd0,  1, 0, 0));
      tbl.push_back(mk("t5_orphan",1, 0, 0, 7'h12, 0, 32'h0,        0, 0, 5'd0,  1, 0, 1));
      tbl.push_back(mk("t5_first", 1, 1, 0, 7'h7F, 0, 32'h0,        0, 0, 5'd0,  1, 1, 1));
      tbl.push_back(mk("t5_restrt",1, 1, 0, 7'h01, 0, 32'h0,        0, 0, 5'd0,  1, 1, 1));
      tbl.push_back(mk("t5_v1",    1, 0, 0, 7'h02, 0, 32'h0,        0, 0, 5'd0,  1, 1, 1));
      tbl.push_back(mk("t5_v2",    1, 0, 0, 7'h03, 0, 32'h0,        0, 0, 5'd0,  1, 1, 1));
      tbl.push_back(mk("t5_last",  1, 0, 1, 7'h04, 1, 32'h02081840, 1, 1, 5'd4,  1, 0, 1));

      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
      n_vec++;
      if (bus.word_out !== 32'h0) begin
         n_miss++;
         $display("FAIL reset_word: got %h required %h", bus.word_out, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         apply(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].d);
         check_out(tbl[i].name, tbl[i].wv, tbl[i].wo, tbl[i].fw, tbl[i].lw,
                   tbl[i].pad, tbl[i].rdy, tbl[i].pip, tbl[i].perr);
      end

      // 32 x 7F: a word completes whenever 7*k crosses a multiple of 32
      for (int k = 1; k <= 32; k++) begin
         logic ewv;
         ewv = ((7 * k) / 32) != ((7 * (k - 1)) / 32);
         apply(1'b1, k == 1, k == 32, 7'h7F);
         check_out($sformatf("t4_k%0d", k), ewv, 32'hFFFFFFFF, ewv && (k == 5),
                   ewv && (k == 32), 5'd0, 1'b1, k != 32, 1'b1);
      end
      apply(1'b0, 1'b0, 1'b0, 7'h00);
      check_out("t4_after", 0, 32'h0, 0, 0, 5'd0, 1, 0, 1);

      for (int k = 0; k < 3; k++) begin
         apply(1'b1, k == 0, 1'b0, 7'h7F);
         check_out($sformatf("t6_v%0d", k), 0, 32'h0, 0, 0, 5'd0, 1, 1, 1);
      end
      @(negedge clk);
      bus.valid_in    = 1'b0;
      bus.first_value = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_out("t6_async", 0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
      @(posedge clk);
      #1;
      check_out("t6_held", 0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         apply(1'b0, 1'b0, 1'b0, 7'h00);
         check_out($sformatf("t6_quiet%0d", k), 0, 32'h0, 0, 0, 5'd0, 1, 0, 0);
      end
      apply(1'b1, 1'b1, 1'b1, 7'h55);
      check_out("t6_clean", 1, 32'hAA000000, 1, 1, 5'd25, 1, 0, 0);
      apply(1'b0, 1'b0, 1'b0, 7'h00);
      check_out("t6_end", 0, 32'h0, 0, 0, 5'd0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
